// File: rtl/frame_rx.sv
// frame_rx: oversampling serial frame receiver.
//
// A frame is one low start bit, 9 data bits sent LSB first, an optional
// even-parity bit, and one high stop bit. Each bit lasts BIT_CLKS clk cycles.
// Every bit is sampled once, at its midpoint, by a down-counter.
//
// Optional feature: define FRAME_RX_PARITY_EN to add a parity bit after the
// data bits. Even parity is required over the 9 data bits plus the parity bit.
//
// Ports:
//   clk         - single clock; all state changes on its rising edge
//   rst         - asynchronous, active-high reset
//   rx          - asynchronous serial input; idles high
//   frame       - last accepted frame; bit 0 is the first data bit received
//   frame_valid - one-cycle pulse; frame is updated in the same cycle
//   frame_err   - one-cycle pulse on a bad stop bit or a parity mismatch
//   busy        - high whenever the receiver is not idle
module frame_rx #(
  parameter int unsigned BIT_CLKS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [8:0] frame,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  // The first wait lasts half a bit, so that every later sample falls at the
  // middle of its bit.
  localparam logic [15:0] HALF_RELOAD = 16'(BIT_CLKS / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(BIT_CLKS - 1);

`ifdef FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t      state_q, state_d;
  logic        sync1_q, rxs_q, rxs_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic [8:0]  frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        cnt_zero;
  logic        parity_ok;

`ifdef FRAME_RX_PARITY_EN
  logic        parity_q, parity_d;

  // With even parity, the XOR of all ten bits must be zero.
  assign parity_ok = ~(^{shift_q, parity_q});
`else
  assign parity_ok = 1'b1;
`endif

  assign cnt_zero = (cnt_q == 16'd0);

  // Two-flop synchronizer, plus one more flop that holds the previous
  // synchronized value for falling-edge detection. All three reset to the
  // idle level so that leaving reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

`ifdef FRAME_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  // In every active state, the counter counts down to zero and stops there.
  // At zero, the state samples rxs and reloads the counter. Each pulse is
  // registered, so it comes out in the cycle after the stop sample, together
  // with the new frame value.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
`ifdef FRAME_RX_PARITY_EN
    parity_d      = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = HALF_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rxs_q) begin
          cnt_d     = FULL_RELOAD;
          bit_cnt_d = 4'd0;
          state_d   = DATA;
        end else begin
          // The line went high again before mid-bit, so this was a glitch.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rxs_q, shift_q[8:1]};
          cnt_d   = FULL_RELOAD;
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
`ifdef FRAME_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef FRAME_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          parity_d = rxs_q;
          cnt_d    = FULL_RELOAD;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rxs_q) begin
          if (parity_ok) begin
            frame_d       = shift_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        // The line is held low. Wait for it to go idle before looking for
        // another start bit.
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 SHALL have parameter BIT_CLKS, 868, clk cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port frame  output  9  last accepted frame, LSB = first data bit received.
REQ-006 SHALL have port frame_valid  output  1  one-cycle pulse; frame updated in the same cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on framing error or parity error.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
REQ-011 IDLE: on rxs falling edge (previous 1, current 0), SHALL load bit counter with BIT_CLKS/2 - 1 (integer division) and go to START.
REQ-012 START: at counter zero, SHALL sample rxs; 0 -> DATA with counter reloaded to BIT_CLKS-1; 1 -> glitch, return to IDLE with no pulse.
REQ-013 DATA: SHALL sample rxs each time the counter reaches zero, shifting in LSB first, 9 samples total, reloading BIT_CLKS-1 after each.
REQ-014 After 9th data sample SHALL go to STOP (or PARITY when the macro is defined).
REQ-015 STOP: at counter zero, rxs=1 SHALL write shift register to frame and pulse frame_valid on the next clk edge, then return to IDLE.
REQ-016 STOP: at counter zero, rxs=0 SHALL pulse frame_err, leave frame unchanged, and go to BREAK.
REQ-017 BREAK: SHALL wait until rxs=1, then enter IDLE; no start detection while in BREAK.
REQ-018 frame_valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per event.
REQ-019 frame SHALL hold its value between accepted frames.
REQ-020 Bit counter SHALL be 16 bits, count down, never wrap below zero.
REQ-021 A falling edge arriving in the same cycle as return to IDLE SHALL be detected (back-to-back frames with one stop bit accepted).
REQ-022 Total latency: frame_valid SHALL rise 2 (synchronizer) + BIT_CLKS/2 + 10*BIT_CLKS cycles after the rx falling edge, +/-1 cycle.

Reset
REQ-023 rst high SHALL immediately force IDLE, frame=0, frame_valid=0, frame_err=0, busy=0, counters and shift register 0, synchronizer flops 1.
REQ-024 rst asserted mid-frame SHALL discard the partial frame with no pulse; reception resumes on the first falling edge after rst release.

Configuration
REQ-025 Macro FRAME_RX_PARITY_EN, when defined, SHALL add state PARITY sampling one bit after data; even parity over the 9 data bits plus the parity bit required.
REQ-026 With FRAME_RX_PARITY_EN, parity mismatch SHALL pulse frame_err after the STOP sample (regardless of the stop value) and leave frame unchanged; a bad stop also enters BREAK.
REQ-027 Without FRAME_RX_PARITY_EN, the frame SHALL be start + 9 data + stop, and no parity logic SHALL be present.

Verification
REQ-028 BIT_CLKS=16, no macro: send 9'h1A5 with valid stop -> single frame_valid pulse, frame=9'h1A5, frame_err never high.
REQ-029 Low glitch of 3 cycles on idle rx -> return to IDLE, busy drops, no pulse of either output.
REQ-030 Send 9'h0F0 with stop bit held low for 40 cycles -> frame_err pulse, frame keeps previous value, no new start until rx high.
REQ-031 Two back-to-back frames 9'h001, 9'h1FF with one stop bit each -> two frame_valid pulses, frame=9'h001 then 9'h1FF.
REQ-032 Assert rst during the 5th data bit of 9'h155 -> all outputs 0 immediately; following frame 9'h0AA received correctly.
REQ-033 With FRAME_RX_PARITY_EN: 9'h003 with parity 0 -> frame_valid; same data with parity 1 -> frame_err, frame unchanged.
